// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipeline, downstream of execute. Performs a multi-cycle
// access to an internal word memory with a fixed access latency, raises
// `stall` to freeze the upstream stages while the access is in flight, and
// drives the MEM/WB pipeline register feeding write-back.
//
// Parameters
//   DEPTH    data memory depth in 32-bit words (power of two, >= 2)
//   LATENCY  cycles `stall` stays high per access; 0 = single-cycle, no stall
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   wb_en_in       write-back enable from execute
//   mem_r_en_in    load request
//   mem_w_en_in    store request
//   alu_res_in     byte address for loads/stores, pass-through result otherwise
//   val_rm_in      store data
//   dest_in        destination register
//   stall          freeze request to PC/IF/ID/EXE and their pipeline registers
//   wb_en_out      MEM/WB write-back enable
//   mem_r_en_out   MEM/WB load flag (selects mem_data_out in WB)
//   alu_res_out    MEM/WB ALU result
//   mem_data_out   MEM/WB load data (0 for non-loads)
//   dest_out       MEM/WB destination register
//
// State   | Meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no access in flight; pass-through, or start of a new access
// S_WAIT  | access in flight, counter running down, stall held high
// S_DONE  | access completes; memory read/write, MEM/WB captures results
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        stall,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  localparam int AW = $clog2(DEPTH);
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            req;
  logic            access;
  logic            stall_int;
  logic [31:0]     addr_off;
  logic [AW-1:0]   index;
  logic [31:0]     rd_data;
  logic            unused_addr_bits;
  logic [31:0]     mem [DEPTH];

  assign req = mem_r_en_in | mem_w_en_in;

  // Data memory is based at byte address 1024; the word index wraps modulo
  // DEPTH and the byte offset within the word is ignored.
  assign addr_off         = alu_res_in - 32'd1024;
  assign index            = addr_off[AW+1:2];
  assign unused_addr_bits = ^{addr_off[31:AW+2], addr_off[1:0]};

  // Asynchronous read so DONE sees the pre-store word when both enables
  // are set.
  assign rd_data = mem[index];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_int = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            access = 1'b1;
          end else begin
            stall_int = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_int = 1'b1;
        cnt_nxt   = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        access    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Reset must silence the freeze request immediately, not one edge later.
  assign stall = rst & stall_int;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_int) begin
        // Bubble into WB; data fields keep their last values.
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
      end else begin
        wb_en_out    <= wb_en_in;
        mem_r_en_out <= mem_r_en_in;
        alu_res_out  <= alu_res_in;
        dest_out     <= dest_in;
        mem_data_out <= mem_r_en_in ? rd_data : 32'd0;
      end
    end
  end

  // Memory contents survive reset; a store caught by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (rst && access && mem_w_en_in) begin
      mem[index] <= val_rm_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        wb_en_in     [3];
  logic        mem_r_en_in  [3];
  logic        mem_w_en_in  [3];
  logic [31:0] alu_res_in   [3];
  logic [31:0] val_rm_in    [3];
  logic [3:0]  dest_in      [3];
  logic        stall        [3];
  logic        wb_en_out    [3];
  logic        mem_r_en_out [3];
  logic [31:0] alu_res_out  [3];
  logic [31:0] mem_data_out [3];
  logic [3:0]  dest_out     [3];

  int checks;
  int failures;

  // Reference memory per DUT: contents plus a written flag (unwritten words
  // have no defined value).
  logic [31:0] mdl [3][DEPTH];
  bit          vld [3][DEPTH];

  // dut 0: LATENCY=4, dut 1: LATENCY=0, dut 2: LATENCY=1
  mem_stage #(.DEPTH(DEPTH), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in[0]), .mem_r_en_in(mem_r_en_in[0]), .mem_w_en_in(mem_w_en_in[0]),
    .alu_res_in(alu_res_in[0]), .val_rm_in(val_rm_in[0]), .dest_in(dest_in[0]),
    .stall(stall[0]), .wb_en_out(wb_en_out[0]), .mem_r_en_out(mem_r_en_out[0]),
    .alu_res_out(alu_res_out[0]), .mem_data_out(mem_data_out[0]), .dest_out(dest_out[0])
  );

  mem_stage #(.DEPTH(DEPTH), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in[1]), .mem_r_en_in(mem_r_en_in[1]), .mem_w_en_in(mem_w_en_in[1]),
    .alu_res_in(alu_res_in[1]), .val_rm_in(val_rm_in[1]), .dest_in(dest_in[1]),
    .stall(stall[1]), .wb_en_out(wb_en_out[1]), .mem_r_en_out(mem_r_en_out[1]),
    .alu_res_out(alu_res_out[1]), .mem_data_out(mem_data_out[1]), .dest_out(dest_out[1])
  );

  mem_stage #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in[2]), .mem_r_en_in(mem_r_en_in[2]), .mem_w_en_in(mem_w_en_in[2]),
    .alu_res_in(alu_res_in[2]), .val_rm_in(val_rm_in[2]), .dest_in(dest_in[2]),
    .stall(stall[2]), .wb_en_out(wb_en_out[2]), .mem_r_en_out(mem_r_en_out[2]),
    .alu_res_out(alu_res_out[2]), .mem_data_out(mem_data_out[2]), .dest_out(dest_out[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'd1024;
    return int'((off / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic drive(input int d, input logic r, input logic w, input logic wbe,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] dst);
    mem_r_en_in[d] = r;
    mem_w_en_in[d] = w;
    wb_en_in[d]    = wbe;
    alu_res_in[d]  = addr;
    val_rm_in[d]   = data;
    dest_in[d]     = dst;
  endtask

  // One instruction on DUT d, entered at posedge+1 and left at posedge+1
  // just after its results land in MEM/WB.
  task automatic do_op(input int d, input logic r, input logic w, input logic wbe,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] dst, output logic [31:0] got);
    int          idx;
    int          exp_st;
    logic [31:0] exp_rd;
    bit          rd_known;
    idx      = word_index(addr);
    exp_st   = (r | w) ? lat_of(d) : 0;
    exp_rd   = r ? mdl[d][idx] : 32'd0;
    rd_known = !r || vld[d][idx];
    drive(d, r, w, wbe, addr, data, dst);
    for (int k = 0; k <= exp_st; k++) begin
      @(negedge clk);
      checks++;
      if (stall[d] !== (k < exp_st)) begin
        failures++;
        $display("FAIL stall dut%0d cycle%0d got=%b exp=%b", d, k, stall[d], (k < exp_st));
      end
      @(posedge clk);
      #1;
      if (k < exp_st) begin
        checks++;
        if ({wb_en_out[d], mem_r_en_out[d]} !== 2'b00) begin
          failures++;
          $display("FAIL bubble dut%0d cycle%0d got wb=%b r=%b exp 0 0",
                   d, k, wb_en_out[d], mem_r_en_out[d]);
        end
      end
    end
    checks++;
    if ({wb_en_out[d], mem_r_en_out[d], alu_res_out[d], dest_out[d]} !== {wbe, r, addr, dst}) begin
      failures++;
      $display("FAIL memwb dut%0d got wb=%b r=%b alu=%h dst=%0d exp wb=%b r=%b alu=%h dst=%0d",
               d, wb_en_out[d], mem_r_en_out[d], alu_res_out[d], dest_out[d], wbe, r, addr, dst);
    end
    if (rd_known) begin
      checks++;
      if (mem_data_out[d] !== exp_rd) begin
        failures++;
        $display("FAIL mem_data dut%0d addr=%h got=%h exp=%h", d, addr, mem_data_out[d], exp_rd);
      end
    end
    if (w) begin
      mdl[d][idx] = data;
      vld[d][idx] = 1'b1;
    end
    got = mem_data_out[d];
    mem_r_en_in[d] = 1'b0;
    mem_w_en_in[d] = 1'b0;
    wb_en_in[d]    = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({stall[d], wb_en_out[d], mem_r_en_out[d], alu_res_out[d], mem_data_out[d], dest_out[d]} !== '0) begin
        failures++;
        $display("FAIL %s dut%0d got stall=%b wb=%b r=%b alu=%h data=%h dst=%0d exp all 0",
                 tag, d, stall[d], wb_en_out[d], mem_r_en_out[d], alu_res_out[d],
                 mem_data_out[d], dest_out[d]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1, 32'd1036, 32'h0BAD_F00D, 4'd5);
    drive(1, 1'b1, 1'b0, 1'b1, 32'd1040, 32'h0, 4'd6);
    drive(2, 1'b1, 1'b1, 1'b1, 32'd1044, 32'h1, 4'd7);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst = 1'b1;
    // Request still present at release: full wait starts in the first cycle.
    do_op(0, 1'b0, 1'b1, 1'b1, 32'd1036, 32'h0BAD_F00D, 4'd5, got);
  endtask

  task automatic test_pass_through();
    logic [31:0] got;
    do_op(0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 4'd3, got);
    checks++;
    if (alu_res_out[0] !== 32'h1234_5678 || wb_en_out[0] !== 1'b1 || dest_out[0] !== 4'd3) begin
      failures++;
      $display("FAIL pass_through got alu=%h wb=%b dst=%0d exp 12345678 1 3",
               alu_res_out[0], wb_en_out[0], dest_out[0]);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] got;
    do_op(0, 1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 4'd0, got);
    do_op(0, 1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd9, got);
    checks++;
    if (got !== 32'hDEAD_BEEF || dest_out[0] !== 4'd9 || mem_r_en_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL store_load got data=%h dst=%0d r=%b exp deadbeef 9 1",
               got, dest_out[0], mem_r_en_out[0]);
    end
    // Combined load+store returns the pre-store word.
    do_op(0, 1'b1, 1'b1, 1'b1, 32'd1033, 32'hCAFE_0001, 4'd2, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_store_old got=%h exp=deadbeef", got);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    do_op(0, 1'b0, 1'b1, 1'b0, 32'd1024 + 32'd256, 32'h0000_00A5, 4'd1, got);
    do_op(0, 1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd4, got);
    checks++;
    if (got !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL wrap got=%h exp=000000a5", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    do_op(0, 1'b0, 1'b1, 1'b0, 32'd1064, 32'h0000_0011, 4'd0, got);
    drive(0, 1'b0, 1'b1, 1'b1, 32'd1064, 32'h0000_0055, 4'd8);
    @(negedge clk);
    checks++;
    if (stall[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_stall1 got=%b exp=1", stall[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_forced got=%b exp=0", stall[0]);
    end
    @(posedge clk);
    #1;
    check_cleared("reset_mid");
    rst = 1'b1;
    do_op(0, 1'b0, 1'b1, 1'b1, 32'd1064, 32'h0000_0055, 4'd8, got);
    do_op(0, 1'b1, 1'b0, 1'b1, 32'd1064, 32'h0, 4'd8, got);
    checks++;
    if (got !== 32'h0000_0055) begin
      failures++;
      $display("FAIL reset_mid_data got=%h exp=00000055", got);
    end
  endtask

  task automatic test_lat_builds();
    logic [31:0] got;
    for (int d = 1; d < 3; d++) begin
      do_op(d, 1'b0, 1'b1, 1'b0, 32'd1100, 32'h7777_0000 + 32'(d), 4'd0, got);
      do_op(d, 1'b1, 1'b0, 1'b1, 32'd1100, 32'h0, 4'd12, got);
      checks++;
      if (got !== 32'h7777_0000 + 32'(d)) begin
        failures++;
        $display("FAIL lat_build dut%0d got=%h exp=%h", d, got, 32'h7777_0000 + 32'(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic [31:0] addr;
    int          d;
    int          kind;
    for (int i = 0; i < 90; i++) begin
      d    = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)
        addr = $urandom;
      else
        addr = 32'd1024 + 32'($urandom_range(0, 95)) * 32'd4 + 32'($urandom_range(0, 3));
      do_op(d, (kind == 1) || (kind == 3), (kind == 2) || (kind == 3), 1'($urandom_range(0, 1)),
            addr, $urandom, 4'($urandom_range(0, 15)), got);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
      for (int j = 0; j < DEPTH; j++) begin
        mdl[d][j] = 32'h0;
        vld[d][j] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_store_load();
    test_wrap();
    test_reset_mid();
    test_lat_builds();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
